// File: rtl/prog_fault_mem.sv
// Pipelined word memory (read latency 2) with a programmable table of fault-injection slots.
// Define FAULT_LOG_EN to add the fault_hit / fault_cnt logging outputs.
module prog_fault_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned NUM_FAULTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_en,
  input  logic                          write_read,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rvalid,
  input  logic                          cfg_we,
  input  logic [3:0]                    cfg_slot,
  input  logic [2:0]                    cfg_type,
  input  logic [ADDR_WIDTH-1:0]         cfg_vaddr,
  input  logic [ADDR_WIDTH-1:0]         cfg_aaddr,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_vbit,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_abit,
  input  logic [1:0]                    cfg_pat
`ifdef FAULT_LOG_EN
  ,
  output logic                          fault_hit,
  output logic [15:0]                   fault_cnt
`endif
);

  localparam int unsigned BitW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    FtOff  = 3'd0,
    FtSa0  = 3'd1,
    FtSa1  = 3'd2,
    FtTfUp = 3'd3,
    FtTfDn = 3'd4,
    FtCfid = 3'd5,
    FtNpsf = 3'd6,
    FtRsvd = 3'd7
  } fault_e;

  logic                  req_en_q;
  logic                  req_wr_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic                  rd_pend_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  fault_e                s_type_q [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] s_va_q   [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] s_aa_q   [NUM_FAULTS];
  logic [BitW-1:0]       s_vb_q   [NUM_FAULTS];
  logic [BitW-1:0]       s_ab_q   [NUM_FAULTS];
  logic [1:0]            s_pat_q  [NUM_FAULTS];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  in_range;
  logic                  do_wr;
  logic                  do_rd;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  nb_hi;
  logic                  nb_lo;
`ifdef FAULT_LOG_EN
  logic                  cfid_hit;
`endif

  // Slots are applied in ascending order to the word being stored; stuck-at slots run last.
  always_comb begin
    mem_d    = mem_q;
    in_range = 32'(req_addr_q) < DEPTH;
    do_wr    = req_en_q && req_wr_q && in_range;
    do_rd    = req_en_q && !req_wr_q;
    old_word = in_range ? mem_q[req_addr_q] : '0;
    wr_word  = req_wdata_q;
    nb_hi    = 1'b0;
    nb_lo    = 1'b0;
`ifdef FAULT_LOG_EN
    cfid_hit = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
      case (s_type_q[i])
        FtTfUp: begin
          if (do_wr && s_va_q[i] == req_addr_q && !old_word[s_vb_q[i]] && wr_word[s_vb_q[i]])
            wr_word[s_vb_q[i]] = 1'b0;
        end
        FtTfDn: begin
          if (do_wr && s_va_q[i] == req_addr_q && old_word[s_vb_q[i]] && !wr_word[s_vb_q[i]])
            wr_word[s_vb_q[i]] = 1'b1;
        end
        FtCfid: begin
          if (do_wr && s_aa_q[i] == req_addr_q && !old_word[s_ab_q[i]] &&
              req_wdata_q[s_ab_q[i]]) begin
            if (s_va_q[i] == req_addr_q) begin
              wr_word[s_vb_q[i]] = ~wr_word[s_vb_q[i]];
            end else if (32'(s_va_q[i]) < DEPTH) begin
              mem_d[s_va_q[i]][s_vb_q[i]] = ~mem_d[s_va_q[i]][s_vb_q[i]];
`ifdef FAULT_LOG_EN
              cfid_hit = 1'b1;
`endif
            end
          end
        end
        FtNpsf: begin
          if (do_wr && s_va_q[i] == req_addr_q) begin
            // Neighbours come from the pre-edge array; off-array neighbours read as 0.
            nb_hi = (32'(s_va_q[i]) + 32'd1 < DEPTH) ?
                    mem_q[s_va_q[i] + ADDR_WIDTH'(1)][s_ab_q[i]] : 1'b0;
            nb_lo = (s_va_q[i] != '0) ? mem_q[s_va_q[i] - ADDR_WIDTH'(1)][s_ab_q[i]] : 1'b0;
            if ({nb_hi, nb_lo} == s_pat_q[i]) wr_word[s_vb_q[i]] = old_word[s_vb_q[i]];
          end
        end
        default: ;
      endcase
    end
    for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
      if (do_wr && s_va_q[i] == req_addr_q) begin
        if (s_type_q[i] == FtSa0) wr_word[s_vb_q[i]] = 1'b0;
        else if (s_type_q[i] == FtSa1) wr_word[s_vb_q[i]] = 1'b1;
      end
    end
    if (do_wr) mem_d[req_addr_q] = wr_word;

    rd_word = old_word;
    for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
      if (in_range && s_va_q[i] == req_addr_q) begin
        if (s_type_q[i] == FtSa0) rd_word[s_vb_q[i]] = 1'b0;
        else if (s_type_q[i] == FtSa1) rd_word[s_vb_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_en_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_data_q   <= '0;
      rdata       <= '0;
      rvalid      <= 1'b0;
      for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
        s_type_q[i] <= FtOff;
        s_va_q[i]   <= '0;
        s_aa_q[i]   <= '0;
        s_vb_q[i]   <= '0;
        s_ab_q[i]   <= '0;
        s_pat_q[i]  <= '0;
      end
    end else begin
      req_en_q    <= mem_en;
      req_wr_q    <= write_read;
      req_addr_q  <= address;
      req_wdata_q <= wdata;
      rd_pend_q   <= do_rd;
      if (do_rd) rd_data_q <= rd_word;
      rvalid <= rd_pend_q;
      if (rd_pend_q) rdata <= rd_data_q;
      for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
        if (cfg_we && cfg_slot == 4'(i)) begin
          s_type_q[i] <= fault_e'(cfg_type);
          s_va_q[i]   <= cfg_vaddr;
          s_aa_q[i]   <= cfg_aaddr;
          s_vb_q[i]   <= cfg_vbit;
          s_ab_q[i]   <= cfg_abit;
          s_pat_q[i]  <= cfg_pat;
        end
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef FAULT_LOG_EN
  logic hit;
  assign hit = (do_wr && (wr_word != req_wdata_q || cfid_hit)) ||
               (do_rd && rd_word != old_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_hit <= 1'b0;
      fault_cnt <= '0;
    end else begin
      fault_hit <= hit;
      if (hit && fault_cnt != 16'hFFFF) fault_cnt <= fault_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_fault_mem.sv
// Bench for prog_fault_mem: directed vector table plus randomized traffic against a word-level model.
module tb_prog_fault_mem;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 48;
  localparam int NF    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          cfg_we;
  logic [3:0]    cfg_slot;
  logic [2:0]    cfg_type;
  logic [AW-1:0] cfg_vaddr;
  logic [AW-1:0] cfg_aaddr;
  logic [2:0]    cfg_vbit;
  logic [2:0]    cfg_abit;
  logic [1:0]    cfg_pat;
`ifdef FAULT_LOG_EN
  logic          fault_hit;
  logic [15:0]   fault_cnt;
`endif

  prog_fault_mem #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .NUM_FAULTS(NF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .write_read(write_read),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .cfg_we    (cfg_we),
    .cfg_slot  (cfg_slot),
    .cfg_type  (cfg_type),
    .cfg_vaddr (cfg_vaddr),
    .cfg_aaddr (cfg_aaddr),
    .cfg_vbit  (cfg_vbit),
    .cfg_abit  (cfg_abit),
    .cfg_pat   (cfg_pat)
`ifdef FAULT_LOG_EN
    ,
    .fault_hit (fault_hit),
    .fault_cnt (fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit cw;   int slot; int ftype; int va; int aa; int vb; int ab; int pat;
    bit en;   bit wr;   int addr;  int data;
    bit chk;  int exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Word-level reference state
  int m_mem  [DEPTH];
  int s_type [NF];
  int s_va   [NF];
  int s_aa   [NF];
  int s_vb   [NF];
  int s_ab   [NF];
  int s_pat  [NF];
  bit p_v [2];
  bit p_t [2];
  int p_d [2];
  int exp_rdata;

  vec_t vec_a[$];
  vec_t vec_b[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int bitof(input int w, input int b);
    return (w >> b) & 1;
  endfunction

  function automatic void m_clear_slots();
    for (int s = 0; s < NF; s++) s_type[s] = 0;
  endfunction

  function automatic void m_cfg(input vec_t v);
    if (v.slot < NF) begin
      s_type[v.slot] = (v.ftype == 7) ? 0 : v.ftype;
      s_va[v.slot]   = v.va;
      s_aa[v.slot]   = v.aa;
      s_vb[v.slot]   = v.vb;
      s_ab[v.slot]   = v.ab;
      s_pat[v.slot]  = v.pat;
    end
  endfunction

  function automatic void m_write(input int addr, input int data);
    int snap[DEPTH];
    int w;
    int old;
    int hi;
    int lo;
    if (addr >= DEPTH) return;
    snap = m_mem;
    old  = m_mem[addr];
    w    = data;
    for (int s = 0; s < NF; s++) begin
      if (s_type[s] == 3 && s_va[s] == addr && bitof(old, s_vb[s]) == 0 && bitof(w, s_vb[s]) == 1)
        w = w & ~(1 << s_vb[s]);
      if (s_type[s] == 4 && s_va[s] == addr && bitof(old, s_vb[s]) == 1 && bitof(w, s_vb[s]) == 0)
        w = w | (1 << s_vb[s]);
      if (s_type[s] == 5 && s_aa[s] == addr && bitof(old, s_ab[s]) == 0 &&
          bitof(data, s_ab[s]) == 1) begin
        if (s_va[s] == addr) w = w ^ (1 << s_vb[s]);
        else if (s_va[s] < DEPTH) m_mem[s_va[s]] = m_mem[s_va[s]] ^ (1 << s_vb[s]);
      end
      if (s_type[s] == 6 && s_va[s] == addr) begin
        hi = (s_va[s] + 1 < DEPTH) ? bitof(snap[s_va[s] + 1], s_ab[s]) : 0;
        lo = (s_va[s] > 0) ? bitof(snap[s_va[s] - 1], s_ab[s]) : 0;
        if (hi * 2 + lo == s_pat[s]) w = (w & ~(1 << s_vb[s])) | (old & (1 << s_vb[s]));
      end
    end
    for (int s = 0; s < NF; s++) begin
      if (s_va[s] == addr && s_type[s] == 1) w = w & ~(1 << s_vb[s]);
      if (s_va[s] == addr && s_type[s] == 2) w = w | (1 << s_vb[s]);
    end
    m_mem[addr] = w & 'hFF;
  endfunction

  function automatic int m_read(input int addr);
    int r;
    if (addr >= DEPTH) return 0;
    r = m_mem[addr];
    for (int s = 0; s < NF; s++) begin
      if (s_va[s] == addr && s_type[s] == 1) r = r & ~(1 << s_vb[s]);
      if (s_va[s] == addr && s_type[s] == 2) r = r | (1 << s_vb[s]);
    end
    return r;
  endfunction

  function automatic vec_t idle_v();
    vec_t v;
    v = '{cw: 0, slot: 0, ftype: 0, va: 0, aa: 0, vb: 0, ab: 0, pat: 0,
          en: 0, wr: 0, addr: 0, data: 0, chk: 0, exp: 0};
    return v;
  endfunction

  function automatic vec_t w_v(input int a, input int d);
    vec_t v;
    v = idle_v(); v.en = 1; v.wr = 1; v.addr = a; v.data = d;
    return v;
  endfunction

  function automatic vec_t r_v(input int a, input int e);
    vec_t v;
    v = idle_v(); v.en = 1; v.addr = a; v.chk = 1; v.exp = e;
    return v;
  endfunction

  function automatic vec_t c_v(input int sl, input int t, input int va, input int aa,
                               input int vb, input int ab, input int pat);
    vec_t v;
    v = idle_v(); v.cw = 1; v.slot = sl; v.ftype = t;
    v.va = va; v.aa = aa; v.vb = vb; v.ab = ab; v.pat = pat;
    return v;
  endfunction

  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 16) return r;
    if (r < 18) return DEPTH - 1 - (r - 16);
    return int'($urandom_range(DEPTH, 63));
  endfunction

  // One cycle: drive, advance the model, clock, compare outputs against the expected pipeline.
  task automatic step(input vec_t v);
    bit nv;
    bit nt;
    int nd;
    bit ov;
    bit ot;
    int od;
    cfg_we     = v.cw;
    cfg_slot   = 4'(v.slot);
    cfg_type   = 3'(v.ftype);
    cfg_vaddr  = AW'(v.va);
    cfg_aaddr  = AW'(v.aa);
    cfg_vbit   = 3'(v.vb);
    cfg_abit   = 3'(v.ab);
    cfg_pat    = 2'(v.pat);
    mem_en     = v.en;
    write_read = v.wr;
    address    = AW'(v.addr);
    wdata      = DW'(v.data);
    if (v.cw) m_cfg(v);
    nv = 0; nt = 0; nd = 0;
    if (v.en) begin
      if (v.wr) m_write(v.addr, v.data);
      else begin
        nv = 1;
        nt = v.chk;
        nd = v.chk ? v.exp : m_read(v.addr);
      end
    end
    @(posedge clk);
    #1;
    ov = p_v[1]; ot = p_t[1]; od = p_d[1];
    p_v[1] = p_v[0]; p_t[1] = p_t[0]; p_d[1] = p_d[0];
    p_v[0] = nv;     p_t[0] = nt;     p_d[0] = nd;
    check("rvalid", int'(rvalid), int'(ov));
    if (ov) exp_rdata = od;
    check(ot ? "tbl_rdata" : "rdata", int'(rdata), exp_rdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step_inputs_zero();
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 0;
    m_clear_slots();
    for (int k = 0; k < 2; k++) begin p_v[k] = 0; p_t[k] = 0; p_d[k] = 0; end
    exp_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", int'(rvalid), 0);
    check("reset_rdata", int'(rdata), 0);
    rst = 1'b0;

    // Known array contents before any fault is armed
    for (int a = 0; a < DEPTH; a++) step(w_v(a, 0));

    vec_a.push_back(c_v(0, 2, 5, 0, 2, 0, 0));
    vec_a.push_back(w_v(3, 'hA5));  vec_a.push_back(r_v(3, 'hA5));
    vec_a.push_back(w_v(5, 'h00));  vec_a.push_back(r_v(5, 'h04));
    vec_a.push_back(c_v(1, 3, 7, 0, 0, 0, 0));
    vec_a.push_back(w_v(7, 'h00));  vec_a.push_back(w_v(7, 'hFF));  vec_a.push_back(r_v(7, 'hFE));
    vec_a.push_back(c_v(2, 5, 20, 10, 7, 1, 0));
    vec_a.push_back(w_v(20, 'h00)); vec_a.push_back(w_v(10, 'h00));
    vec_a.push_back(w_v(10, 'h02)); vec_a.push_back(r_v(20, 'h80));
    vec_a.push_back(c_v(3, 6, 0, 0, 3, 3, 2));
    vec_a.push_back(w_v(1, 'h08));  vec_a.push_back(w_v(0, 'h00));
    vec_a.push_back(w_v(0, 'hFF));  vec_a.push_back(r_v(0, 'hF7));
    vec_a.push_back(c_v(9, 2, 30, 0, 0, 0, 0));
    vec_a.push_back(w_v(30, 'h00)); vec_a.push_back(r_v(30, 'h00));
    vec_a.push_back(w_v(50, 'h5A)); vec_a.push_back(r_v(50, 'h00));
    vec_a.push_back(w_v(47, 'h3C)); vec_a.push_back(r_v(47, 'h3C));
    vec_a.push_back(idle_v());      vec_a.push_back(idle_v());

    vec_b.push_back(w_v(5, 'h00));  vec_b.push_back(r_v(5, 'h00));
    vec_b.push_back(w_v(7, 'h00));  vec_b.push_back(w_v(7, 'hFF));  vec_b.push_back(r_v(7, 'hFF));
    vec_b.push_back(w_v(10, 'h00)); vec_b.push_back(w_v(10, 'h02)); vec_b.push_back(r_v(20, 'h80));
    vec_b.push_back(r_v(3, 'hA5));  vec_b.push_back(r_v(0, 'hF7));
    vec_b.push_back(idle_v());      vec_b.push_back(idle_v());

    foreach (vec_a[i]) step(vec_a[i]);

    // Reset lands while a read is in flight: it must never emerge.
    step(r_v(5, 'h04));
    #2 rst = 1'b1;
    #1;
    check("rst_async_rvalid", int'(rvalid), 0);
    check("rst_async_rdata", int'(rdata), 0);
    step_inputs_zero();
    @(posedge clk);
    #1;
    check("rst_hold_rvalid", int'(rvalid), 0);
    rst = 1'b0;
    m_clear_slots();
    for (int k = 0; k < 2; k++) begin p_v[k] = 0; p_t[k] = 0; p_d[k] = 0; end
    exp_rdata = 0;
    for (int k = 0; k < 3; k++) step(idle_v());

    foreach (vec_b[i]) step(vec_b[i]);

    for (int n = 0; n < 1500; n++) begin
      vec_t v;
      v = idle_v();
      if ($urandom_range(0, 9) == 0) begin
        v.cw    = 1;
        v.slot  = int'($urandom_range(0, 5));
        v.ftype = int'($urandom_range(0, 7));
        v.va    = pick_addr();
        v.aa    = pick_addr();
        v.vb    = int'($urandom_range(0, 7));
        v.ab    = int'($urandom_range(0, 7));
        v.pat   = int'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) != 0) begin
        v.en   = 1;
        v.wr   = bit'($urandom_range(0, 1));
        v.addr = pick_addr();
        v.data = int'($urandom_range(0, 255));
      end
      step(v);
    end
    step(idle_v());
    step(idle_v());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic step_inputs_zero();
    cfg_we = 0; cfg_slot = '0; cfg_type = '0; cfg_vaddr = '0; cfg_aaddr = '0;
    cfg_vbit = '0; cfg_abit = '0; cfg_pat = '0;
    mem_en = 0; write_read = 0; address = '0; wdata = '0;
  endtask

endmodule

// File: doc/prog_fault_mem.md
PROG_FAULT_MEM -- requirements
Module: prog_fault_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width, minimum 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: address width.
REQ-003 SHALL have parameter DEPTH, default 64: words, at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_FAULTS, default 4: fault slots, 1..16.
REQ-005 SHALL have port clk  in  1  sole clock, all flops on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port mem_en  in  1  access request this cycle.
REQ-008 SHALL have port write_read  in  1  1 = write, 0 = read.
REQ-009 SHALL have port address  in  ADDR_WIDTH  word address.
REQ-010 SHALL have port wdata  in  DATA_WIDTH  write data.
REQ-011 SHALL have port rdata  out  DATA_WIDTH  read data.
REQ-012 SHALL have port rvalid  out  1  rdata valid, one-cycle pulse.
REQ-013 SHALL have port cfg_we  in  1  fault slot write strobe.
REQ-014 SHALL have port cfg_slot  in  4  slot index; index >= NUM_FAULTS ignored.
REQ-015 SHALL have port cfg_type  in  3  0 OFF, 1 SA0, 2 SA1, 3 TF_UP, 4 TF_DN, 5 CFID, 6 NPSF, 7 treated as OFF.
REQ-016 SHALL have ports cfg_vaddr / cfg_aaddr  in  ADDR_WIDTH  victim / aggressor address.
REQ-017 SHALL have ports cfg_vbit / cfg_abit  in  $clog2(DATA_WIDTH)  victim / aggressor bit.
REQ-018 SHALL have port cfg_pat  in  2  NPSF pattern {bit at vaddr+1, bit at vaddr-1}.

Function
REQ-019 SHALL sample mem_en, write_read, address, wdata into a request stage on edge N.
REQ-020 SHALL perform the array operation on edge N+1 and drive rdata with rvalid=1 on edge N+2 for reads (latency 2, one access per cycle, fully pipelined).
REQ-021 SHALL hold rdata between reads; writes SHALL NOT assert rvalid.
REQ-022 SHALL write slot cfg_slot on the cfg_we edge; the slot governs array operations from the following edge; the slot table is cleared only by rst.
REQ-023 SA0/SA1: victim bit SHALL be stored and read as 0/1 regardless of written data.
REQ-024 TF_UP/TF_DN: a write SHALL NOT change the victim bit 0->1 / 1->0; other transitions proceed.
REQ-025 CFID: a write raising aggressor bit 0->1 SHALL invert the victim bit on the same edge; if aggressor and victim share an address, inversion applies to the data being written.
REQ-026 NPSF: a write to the victim address SHALL leave the victim bit unchanged when {mem[vaddr+1][abit], mem[vaddr-1][abit]} equals cfg_pat; neighbours outside 0..DEPTH-1 read as 0.
REQ-027 Several slots on one victim bit SHALL apply in ascending slot order; SA overrides all.
REQ-028 Access with address >= DEPTH SHALL write nothing and read all zeros with rvalid=1.
REQ-029 Read and write of the same address on consecutive cycles SHALL return the newly written (faulted) data.

Reset
REQ-030 rst SHALL immediately clear rdata to 0, rvalid to 0, request stage, and all slots to OFF.
REQ-031 Array contents SHALL NOT be reset; an access in flight at rst assertion SHALL be dropped.

Configuration
REQ-032 Macro FAULT_LOG_EN defined: SHALL add outputs fault_hit (1, pulses on any edge where a fault altered stored or read data) and fault_cnt (16, saturating at 16'hFFFF, cleared by rst).
REQ-033 FAULT_LOG_EN undefined: those ports and counter SHALL NOT exist; all other behaviour identical.

Verification
REQ-034 No faults; write 0xA5 @3, read @3 -> rdata=0xA5, rvalid two cycles after read request.
REQ-035 Slot0 SA1 vaddr=5 vbit=2; write 0x00 @5, read -> 0x04.
REQ-036 Slot1 TF_UP vaddr=7 vbit=0; write 0x00 then 0xFF @7, read -> 0xFE.
REQ-037 Slot2 CFID aaddr=10 abit=1 vaddr=20 vbit=7; write 0x00 @20, 0x00 then 0x02 @10, read @20 -> 0x80.
REQ-038 Slot3 NPSF vaddr=0 vbit=3 abit=3 pat=2'b10; write 0x08 @1, 0x00 @0, then 0xFF @0, read @0 -> 0xF7.
REQ-039 rst asserted during outstanding read -> rvalid stays 0, rdata=0, prior faults inactive afterwards.
